// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared encodings for the multi-cycle CPU control FSM
package mc_defs;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    // State encoding is visible on state_o, so the values are fixed
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_e;

    // ALU operation requested from the ALU control
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Instruction class produced by the opcode decoder
    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_IMM     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    // States whose exit back to FETCH retires an instruction
    function automatic logic is_terminal(state_e s);
        return (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_R_WB) ||
               (s == ST_I_WB)   || (s == ST_BRANCH) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// rtl/mc_op_decode.sv - combinational opcode to instruction-class decoder
module mc_op_decode
    import mc_defs::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode_i,
    output logic [2:0]       class_o
);

    // Map each supported opcode to its class; anything unknown is illegal
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OPC_W'(OP_LW):   class_o = CLS_LOAD;
            OPC_W'(OP_SW):   class_o = CLS_STORE;
            OPC_W'(OP_R):    class_o = CLS_RTYPE;
            OPC_W'(OP_BEQ):  class_o = CLS_BRANCH;
            OPC_W'(OP_J):    class_o = CLS_JUMP;
            OPC_W'(OP_ADDI): class_o = CLS_IMM;
            OPC_W'(OP_ORI):  class_o = CLS_IMM;
            default:         class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle CPU main control FSM (optional MC_PERF_CNT_EN counters)
module mc_control_fsm
    import mc_defs::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
`ifdef MC_PERF_CNT_EN
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt,
`endif
    output logic [3:0]         state_o
);

    state_e       state_q, state_d;
    logic [2:0]   cls_raw;
    instr_class_e cls;

    // The branch decision on zero is taken by the datapath via pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    mc_op_decode #(
        .OPC_W    (OPC_W)
    ) u_op_decode (
        .opcode_i (opcode),
        .class_o  (cls_raw)
    );

    assign cls     = instr_class_e'(cls_raw);
    assign state_o = state_q;

    // State register, forced to FETCH while reset is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; reset blanks every output combinationally
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_W'(ALU_ADD);
        pc_source     = PCSRC_ALU;
        illegal       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM_ADDR;
                    CLS_RTYPE:           state_d = ST_EXEC_R;
                    CLS_BRANCH:          state_d = ST_BRANCH;
                    CLS_JUMP:            state_d = ST_JUMP;
                    CLS_IMM:             state_d = ST_EXEC_I;
                    default:             state_d = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (cls == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_FUNCT);
                state_d   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode == OPC_W'(OP_ORI)) ? ALUOP_W'(ALU_OR)
                                                       : ALUOP_W'(ALU_ADD);
                state_d   = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
                state_d = ST_TRAP;
            end
            // Unused encodings fall into the trap rather than wander
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_B;
            alu_op        = ALUOP_W'(ALU_ADD);
            pc_source     = PCSRC_ALU;
            illegal       = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // Cycle counter freezes in TRAP; instruction counter bumps on retirement
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != ST_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (is_terminal(state_q) && (state_d == ST_FETCH)) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    // Output vector order:
    // [pw pwc irw iod][mr mw m2r rd][rw asa][asb][aop][psrc][ill]
    localparam logic [16:0] E_ZERO  = 17'b0000_0000_00_00_00_00_0;
    localparam logic [16:0] E_F1    = 17'b1010_1000_00_01_00_00_0;
    localparam logic [16:0] E_F0    = 17'b0000_1000_00_01_00_00_0;
    localparam logic [16:0] E_DEC   = 17'b0000_0000_00_11_00_00_0;
    localparam logic [16:0] E_MA    = 17'b0000_0000_01_10_00_00_0;
    localparam logic [16:0] E_MRD   = 17'b0001_1000_00_00_00_00_0;
    localparam logic [16:0] E_MWB   = 17'b0000_0010_10_00_00_00_0;
    localparam logic [16:0] E_MWR   = 17'b0001_0100_00_00_00_00_0;
    localparam logic [16:0] E_XR    = 17'b0000_0000_01_00_10_00_0;
    localparam logic [16:0] E_RWB   = 17'b0000_0001_10_00_00_00_0;
    localparam logic [16:0] E_XI_OR = 17'b0000_0000_01_10_11_00_0;
    localparam logic [16:0] E_IWB   = 17'b0000_0000_10_00_00_00_0;
    localparam logic [16:0] E_BR    = 17'b0100_0000_01_00_01_01_0;
    localparam logic [16:0] E_J     = 17'b1000_0000_00_00_00_10_0;
    localparam logic [16:0] E_TRAP  = 17'b0000_0000_00_00_00_00_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    logic [31:0] cyc_snap;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    wire [16:0] obs = {pc_write, pc_write_cond, ir_write, i_or_d,
                       mem_read, mem_write, mem_to_reg, reg_dst,
                       reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
    wire pc_load = pc_write | (pc_write_cond & zero);

    always #5 clk = ~clk;

    mc_control_fsm #(
        .OPC_W         (6),
        .ALUOP_W       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt),
`endif
        .state_o       (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check state and outputs in the current cycle, then advance one clock
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] ev);
        #2;
        chk({tag, "/state"}, {28'd0, state_o}, {28'd0, st});
        chk({tag, "/out"}, {15'd0, obs}, {15'd0, ev});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/state", {28'd0, state_o}, 32'd0);
        chk("reset/out", {15'd0, obs}, 32'd0);
        rst = 1'b0;

        // LW, no wait states: 0,1,2,3,4 then FETCH
        opcode = 6'b100011;
        cyc("lw0", 4'd0, E_F1);
        cyc("lw1", 4'd1, E_DEC);
        cyc("lw2", 4'd2, E_MA);
        cyc("lw3", 4'd3, E_MRD);
        cyc("lw4", 4'd4, E_MWB);
        chk("lw/back", {28'd0, state_o}, 32'd0);
`ifdef MC_PERF_CNT_EN
        chk("lw/instr_cnt", instr_cnt, 32'd1);
        chk("lw/cycle_cnt", cycle_cnt, 32'd5);
`endif

        // SW with three wait cycles in MEM_WR: seven cycles in total
        opcode = 6'b101011;
        cyc("sw0", 4'd0, E_F1);
        cyc("sw1", 4'd1, E_DEC);
        mem_ready = 1'b0;
        cyc("sw2", 4'd2, E_MA);
        for (int i = 0; i < 3; i++) begin
            cyc("sw_wait", 4'd5, E_MWR);
        end
        mem_ready = 1'b1;
        cyc("sw_done", 4'd5, E_MWR);
        chk("sw/back", {28'd0, state_o}, 32'd0);

        // R-type
        opcode = 6'b000000;
        cyc("r0", 4'd0, E_F1);
        cyc("r1", 4'd1, E_DEC);
        cyc("r2", 4'd6, E_XR);
        cyc("r3", 4'd7, E_RWB);

        // ADDI then ORI: alu_op differs only in EXEC_I
        opcode = 6'b001000;
        cyc("addi0", 4'd0, E_F1);
        cyc("addi1", 4'd1, E_DEC);
        cyc("addi2", 4'd8, E_MA);
        cyc("addi3", 4'd9, E_IWB);
        opcode = 6'b001101;
        cyc("ori0", 4'd0, E_F1);
        cyc("ori1", 4'd1, E_DEC);
        cyc("ori2", 4'd8, E_XI_OR);
        cyc("ori3", 4'd9, E_IWB);

        // BEQ taken, then not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        cyc("beq1_0", 4'd0, E_F1);
        cyc("beq1_1", 4'd1, E_DEC);
        chk("beq1/pc_load", {31'd0, pc_load}, 32'd1);
        cyc("beq1_2", 4'd10, E_BR);
        zero = 1'b0;
        cyc("beq0_0", 4'd0, E_F1);
        cyc("beq0_1", 4'd1, E_DEC);
        chk("beq0/pc_load", {31'd0, pc_load}, 32'd0);
        cyc("beq0_2", 4'd10, E_BR);

        // J, with two fetch wait cycles first
        opcode    = 6'b000010;
        mem_ready = 1'b0;
        cyc("fstall0", 4'd0, E_F0);
        cyc("fstall1", 4'd0, E_F0);
        mem_ready = 1'b1;
        cyc("fstall2", 4'd0, E_F1);
        cyc("j1", 4'd1, E_DEC);
        cyc("j2", 4'd11, E_J);

        // Reset pulse in the middle of MEM_RD
        opcode = 6'b100011;
        cyc("rr0", 4'd0, E_F1);
        cyc("rr1", 4'd1, E_DEC);
        mem_ready = 1'b0;
        cyc("rr2", 4'd2, E_MA);
        #2;
        chk("rr/in_memrd", {28'd0, state_o}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rr/async_state", {28'd0, state_o}, 32'd0);
        chk("rr/async_out", {15'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        chk("rr/held_out", {15'd0, obs}, 32'd0);
        rst       = 1'b0;
        mem_ready = 1'b1;
        cyc("rr_resume", 4'd0, E_F1);
        cyc("rr_dec", 4'd1, E_DEC);
        cyc("rr_ma", 4'd2, E_MA);
        cyc("rr_mrd", 4'd3, E_MRD);
        cyc("rr_mwb", 4'd4, E_MWB);

        // Illegal opcode traps until reset
        opcode = 6'b111111;
        cyc("ill0", 4'd0, E_F1);
`ifdef MC_PERF_CNT_EN
        cyc_snap = cycle_cnt + 32'd1;
`endif
        cyc("ill1", 4'd1, E_DEC);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            opcode    = (i[2]) ? 6'b000000 : 6'b100011;
            cyc("trap", 4'd12, E_TRAP);
        end
`ifdef MC_PERF_CNT_EN
        chk("trap/cycle_frozen", cycle_cnt, cyc_snap);
`endif
        rst = 1'b1;
        #1;
        chk("trap/clear_out", {15'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        cyc("post0", 4'd0, E_F1);
        cyc("post1", 4'd1, E_DEC);
        cyc("post2", 4'd6, E_XR);
        chk("post/illegal", {31'd0, illegal}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
